// File: rtl/alu_seq.sv
// Accumulator ALU with an optional shift-add sequential multiplier.
// Define ALU_SEQ_MUL_EN to build the MQ/M registers, counter and MUL FSM (opcode C).
module alu_seq #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned OP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mq_out,
    output logic             busy,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             neg_flag
);

    localparam int unsigned SUM_W = WIDTH + 1;

    localparam logic [OP_W-1:0] OP_ADD      = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDC     = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB      = 4'h3;
    localparam logic [OP_W-1:0] OP_SUBC     = 4'h4;
    localparam logic [OP_W-1:0] OP_AND      = 4'h5;
    localparam logic [OP_W-1:0] OP_OR       = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR      = 4'h7;
    localparam logic [OP_W-1:0] OP_SHL      = 4'h8;
    localparam logic [OP_W-1:0] OP_SHR      = 4'h9;
    localparam logic [OP_W-1:0] OP_BUSTOACC = 4'hA;
    localparam logic [OP_W-1:0] OP_ACCTOBUS = 4'hB;
    localparam logic [OP_W-1:0] OP_CLRC     = 4'hD;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             flags_upd_c;
    logic             accept_c;
    logic             sub_c;
    logic             cin_c;
    logic [WIDTH-1:0] opnd_c;
    logic [WIDTH:0]   sum_c;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [OP_W-1:0] OP_MUL = 4'hC;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum_c;

    assign busy      = (state_q == S_MUL);
    assign mq_out    = mq_q;
    assign mul_sum_c = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : '0);
`else
    assign busy   = 1'b0;
    assign mq_out = '0;
`endif

    assign accept_c   = op_valid & ~busy;
    assign acc_out    = acc_q;
    assign zero_flag  = z_q;
    assign carry_flag = c_q;
    assign neg_flag   = n_q;
    assign bus_out    = (reset && accept_c && (op == OP_ACCTOBUS)) ? acc_q : '0;

    // Shared adder: subtraction is ACC + ~bus_in + cin
    always_comb begin
        sub_c = (op == OP_SUB) || (op == OP_SUBC);
        case (op)
            OP_ADDC, OP_SUBC: cin_c = c_q;
            OP_SUB:           cin_c = 1'b1;
            default:          cin_c = 1'b0;
        endcase
        opnd_c = bus_in ^ {WIDTH{sub_c}};
        sum_c  = {1'b0, acc_q} + {1'b0, opnd_c} + SUM_W'(cin_c);
    end

    // Next-state for ACC, flags and the multiplier sequencer
    always_comb begin
        acc_d       = acc_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        flags_upd_c = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mq_d    = mq_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        state_d = state_q;
`endif
        if (accept_c) begin
            case (op)
                OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                    acc_d       = sum_c[WIDTH-1:0];
                    c_d         = sum_c[WIDTH];
                    flags_upd_c = 1'b1;
                end
                OP_AND: begin
                    acc_d       = acc_q & bus_in;
                    flags_upd_c = 1'b1;
                end
                OP_OR: begin
                    acc_d       = acc_q | bus_in;
                    flags_upd_c = 1'b1;
                end
                OP_XOR: begin
                    acc_d       = acc_q ^ bus_in;
                    flags_upd_c = 1'b1;
                end
                OP_SHL: begin
                    acc_d       = {acc_q[WIDTH-2:0], 1'b0};
                    c_d         = acc_q[WIDTH-1];
                    flags_upd_c = 1'b1;
                end
                OP_SHR: begin
                    acc_d       = {1'b0, acc_q[WIDTH-1:1]};
                    c_d         = acc_q[0];
                    flags_upd_c = 1'b1;
                end
                OP_BUSTOACC: acc_d = bus_in;
                OP_CLRC:     c_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    mq_d    = acc_q;
                    m_d     = bus_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_MUL;
                end
`endif
                default: ;
            endcase
        end
`ifdef ALU_SEQ_MUL_EN
        // One shift-add step per cycle; {carry, ACC, MQ} shifts right as a unit
        if (state_q == S_MUL) begin
            acc_d = mul_sum_c[WIDTH:1];
            mq_d  = {mul_sum_c[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                z_d     = (acc_d == '0) && (mq_d == '0);
                n_d     = acc_d[WIDTH-1];
                c_d     = 1'b0;
            end
        end
`endif
        if (flags_upd_c) begin
            z_d = (acc_d == '0);
            n_d = acc_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            c_q   <= c_d;
            z_q   <= z_d;
            n_q   <= n_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mq_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mq_q    <= mq_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): vector table through a scoreboard,
// plus hand sequences for MUL (or its NOP behaviour) and reset mid-operation.
module tb_alu_seq;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   op;
    logic         op_valid;
    logic [W-1:0] bus_in;
    logic [W-1:0] bus_out;
    logic [W-1:0] acc_out;
    logic [W-1:0] mq_out;
    logic         busy;
    logic         zero_flag;
    logic         carry_flag;
    logic         neg_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic [3:0] bus;
        logic [3:0] exp_bus;
        logic [3:0] exp_acc;
        logic       exp_c;
        logic       exp_z;
        logic       exp_n;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .op_valid   (op_valid),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .acc_out    (acc_out),
        .mq_out     (mq_out),
        .busy       (busy),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .neg_flag   (neg_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] o, input logic [3:0] b,
                                input logic [3:0] eb, input logic [3:0] ea,
                                input logic ec, input logic ez, input logic en);
        vec_t r;
        r.valid = v; r.op = o; r.bus = b; r.exp_bus = eb;
        r.exp_acc = ea; r.exp_c = ec; r.exp_z = ez; r.exp_n = en;
        return r;
    endfunction

    // Drive one op at the falling edge, then score the registered result after the rising edge
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        op_valid = v.valid;
        op       = v.op;
        bus_in   = v.bus;
        #1;
        check({name, " bus_out"}, 32'(bus_out), 32'(v.exp_bus));
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check({name, " acc"}, 32'(acc_out), 32'(e.exp_acc));
            check({name, " czn"}, 32'({carry_flag, zero_flag, neg_flag}),
                  32'({e.exp_c, e.exp_z, e.exp_n}));
            check({name, " busy"}, 32'(busy), 32'(0));
        end
        op_valid = 1'b0;
    endtask

    initial begin
        int busy_cycles;

        // valid, op, bus, exp_bus, exp_acc, c, z, n
        tbl.push_back(mk(1, 4'hA, 4'h9, 4'h0, 4'h9, 0, 0, 0)); // BUSTOACC 9
        tbl.push_back(mk(1, 4'h1, 4'h9, 4'h0, 4'h2, 1, 0, 0)); // ADD 9 -> carry out
        tbl.push_back(mk(1, 4'hA, 4'h5, 4'h0, 4'h5, 1, 0, 0)); // BUSTOACC keeps flags
        tbl.push_back(mk(1, 4'h3, 4'h5, 4'h0, 4'h0, 1, 1, 0)); // SUB 5 -> zero, no borrow
        tbl.push_back(mk(1, 4'h4, 4'h1, 4'h0, 4'hF, 0, 0, 1)); // SUBC 1 -> borrow
        tbl.push_back(mk(1, 4'hA, 4'h3, 4'h0, 4'h3, 0, 0, 1)); // BUSTOACC 3
        tbl.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'h1, 1, 0, 0)); // SHR
        tbl.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'h2, 0, 0, 0)); // SHL
        tbl.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'h4, 0, 0, 0)); // SHL
        tbl.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'h8, 0, 0, 1)); // SHL -> negative
        tbl.push_back(mk(1, 4'h2, 4'h8, 4'h0, 4'h0, 1, 1, 0)); // ADDC 8, C=0 -> wraps
        tbl.push_back(mk(1, 4'h2, 4'h3, 4'h0, 4'h4, 0, 0, 0)); // ADDC 3, C=1
        tbl.push_back(mk(1, 4'h7, 4'hF, 4'h0, 4'hB, 0, 0, 1)); // XOR F
        tbl.push_back(mk(1, 4'h5, 4'h3, 4'h0, 4'h3, 0, 0, 0)); // AND 3
        tbl.push_back(mk(1, 4'h6, 4'hC, 4'h0, 4'hF, 0, 0, 1)); // OR C
        tbl.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'hE, 1, 0, 1)); // SHL shifts out 1
        tbl.push_back(mk(1, 4'hD, 4'h0, 4'h0, 4'hE, 0, 0, 1)); // CLRC
        tbl.push_back(mk(1, 4'h0, 4'h5, 4'h0, 4'hE, 0, 0, 1)); // NOP
        tbl.push_back(mk(1, 4'hE, 4'h1, 4'h0, 4'hE, 0, 0, 1)); // E as NOP
        tbl.push_back(mk(1, 4'hF, 4'h1, 4'h0, 4'hE, 0, 0, 1)); // F as NOP
        tbl.push_back(mk(1, 4'hB, 4'h3, 4'hE, 4'hE, 0, 0, 1)); // ACCTOBUS drives ACC
        tbl.push_back(mk(0, 4'hB, 4'h3, 4'h0, 4'hE, 0, 0, 1)); // ACCTOBUS without valid
        tbl.push_back(mk(0, 4'h1, 4'h1, 4'h0, 4'hE, 0, 0, 1)); // ADD without valid
        tbl.push_back(mk(1, 4'h3, 4'hF, 4'h0, 4'hF, 0, 0, 1)); // SUB F -> borrow
        tbl.push_back(mk(1, 4'hA, 4'h7, 4'h0, 4'h7, 0, 0, 1)); // BUSTOACC 7

        reset    = 1'b0;
        op_valid = 1'b1;
        op       = 4'hB;
        bus_in   = 4'h0;
        #2;
        check("reset bus_out", 32'(bus_out), 32'(0));
        check("reset acc", 32'(acc_out), 32'(0));
        check("reset mq", 32'(mq_out), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset czn", 32'({carry_flag, zero_flag, neg_flag}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef ALU_SEQ_MUL_EN
        // MUL 7*6 = 0x2A; an ADD held during busy must be ignored
        @(negedge clk);
        op_valid = 1'b1;
        op       = 4'hC;
        bus_in   = 4'h6;
        @(posedge clk);
        #1;
        op     = 4'h1;
        bus_in = 4'h1;
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        check("mul busy cycles", 32'(busy_cycles), 32'(4));
        check("mul acc", 32'(acc_out), 32'(4'h2));
        check("mul mq", 32'(mq_out), 32'(4'hA));
        check("mul czn", 32'({carry_flag, zero_flag, neg_flag}), 32'(0));
        @(posedge clk);
        #1;
        check("mul dropped add", 32'(acc_out), 32'(4'h2));
`else
        // Opcode C is a NOP when the multiplier is not built
        @(negedge clk);
        op_valid = 1'b1;
        op       = 4'hC;
        bus_in   = 4'h6;
        busy_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
        end
        op_valid = 1'b0;
        check("nomul busy cycles", 32'(busy_cycles), 32'(0));
        check("nomul acc", 32'(acc_out), 32'(4'h7));
        check("nomul mq", 32'(mq_out), 32'(0));
        check("nomul czn", 32'({carry_flag, zero_flag, neg_flag}), 32'(3'b001));
`endif

        // Reset pulsed on the second cycle of a MUL (a NOP without the multiplier)
        @(negedge clk);
        op_valid = 1'b1;
        op       = 4'hC;
        bus_in   = 4'h6;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        op_valid = 1'b1;
        op       = 4'hB;
        #1;
        check("midreset acc", 32'(acc_out), 32'(0));
        check("midreset mq", 32'(mq_out), 32'(0));
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset bus_out", 32'(bus_out), 32'(0));
        check("midreset czn", 32'({carry_flag, zero_flag, neg_flag}), 32'(0));
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;
        apply(mk(1, 4'h1, 4'h3, 4'h0, 4'h3, 0, 0, 0), "post-reset add");
        check("post-reset mq", 32'(mq_out), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
